// File: rtl/p2s_pkg.sv
// Shared helpers for the parallel-to-serial stream converter.
package p2s_pkg;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Legal configuration: whole number of symbols per word.
    function automatic bit cfg_ok(input int data_w, input int sym_w);
        return (sym_w >= 1) && (sym_w <= data_w) && ((data_w % sym_w) == 0);
    endfunction

endpackage

// File: rtl/p2s_shift_core.sv
// Symbol shift register: loads whole words, emits SYM_W bits per accepted symbol.
module p2s_shift_core
    import p2s_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int SYM_W     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              clr,
    input  logic              ready,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              take,
    output logic              sh_valid,
    output logic              sym_last,
    output logic [SYM_W-1:0]  sym
);

    localparam int N_SYM = DATA_W / SYM_W;
    localparam int CNT_W = clog2_min1(N_SYM);

    logic [DATA_W-1:0] sh_reg;
    logic [DATA_W-1:0] sh_next;
    logic [CNT_W-1:0]  cnt;
    logic              sh_last;
    logic              out_fire;
    logic              word_end;

    assign out_fire = sh_valid & ready;
    assign word_end = out_fire & (cnt == '0);
    // Stage can accept a new word when empty or finishing its last symbol.
    assign take     = !sh_valid | word_end;
    assign sym_last = sh_valid & sh_last & (cnt == '0);

    generate
        if (MSB_FIRST != 0) begin : g_sel_msb
            assign sym = sh_reg[DATA_W-1 -: SYM_W];
        end else begin : g_sel_lsb
            assign sym = sh_reg[SYM_W-1:0];
        end

        if (N_SYM == 1) begin : g_sh_one
            assign sh_next = '0;
        end else if (MSB_FIRST != 0) begin : g_sh_msb
            assign sh_next = {sh_reg[DATA_W-SYM_W-1:0], {SYM_W{1'b0}}};
        end else begin : g_sh_lsb
            assign sh_next = {{SYM_W{1'b0}}, sh_reg[DATA_W-1:SYM_W]};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_reg   <= '0;
            sh_last  <= 1'b0;
            sh_valid <= 1'b0;
            cnt      <= '0;
        end else if (clr) begin
            sh_reg   <= '0;
            sh_last  <= 1'b0;
            sh_valid <= 1'b0;
            cnt      <= '0;
        end else if (take) begin
            if (load) begin
                sh_reg   <= ld_data;
                sh_last  <= ld_last;
                sh_valid <= 1'b1;
                cnt      <= CNT_W'(N_SYM - 1);
            end else begin
                sh_valid <= 1'b0;
            end
        end else if (out_fire) begin
            sh_reg <= sh_next;
            cnt    <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/p2s_stream.sv
// Parallel-to-serial converter with a one-word holding register and
// valid/ready handshakes on both sides.
module p2s_stream
    import p2s_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int SYM_W     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_dv,
    output logic              o_ready,
    output logic [SYM_W-1:0]  o_data,
    output logic              o_last,
    output logic              o_dv,
    input  logic              i_ready,
    output logic              o_busy
);

    generate
        if (!cfg_ok(DATA_W, SYM_W)) begin : g_bad_cfg
            $error("p2s_stream: DATA_W must be a positive multiple of SYM_W");
        end
    endgenerate

    logic [DATA_W-1:0] hd_reg;
    logic              hd_last;
    logic              hd_valid;
    logic              take;
    logic              sh_valid;
    logic              in_fire;
    logic              load;
    logic              direct;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    assign o_ready = !hd_valid;
    assign in_fire = i_dv & o_ready;
    // Held word has priority over a fresh input when the shift stage frees up.
    assign load    = take & (hd_valid | in_fire);
    assign direct  = take & !hd_valid & in_fire;
    assign ld_data = hd_valid ? hd_reg  : i_data;
    assign ld_last = hd_valid ? hd_last : i_last;
    assign o_dv    = sh_valid;
    assign o_busy  = sh_valid | hd_valid;

    p2s_shift_core #(
        .DATA_W   (DATA_W),
        .SYM_W    (SYM_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_core (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr     (i_clr),
        .ready   (i_ready),
        .load    (load),
        .ld_data (ld_data),
        .ld_last (ld_last),
        .take    (take),
        .sh_valid(sh_valid),
        .sym_last(o_last),
        .sym     (o_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hd_reg   <= '0;
            hd_last  <= 1'b0;
            hd_valid <= 1'b0;
        end else if (i_clr) begin
            hd_reg   <= '0;
            hd_last  <= 1'b0;
            hd_valid <= 1'b0;
        end else begin
            if (take & hd_valid)
                hd_valid <= 1'b0;
            // A word not taken straight into the shift stage parks here.
            if (in_fire & !direct) begin
                hd_reg   <= i_data;
                hd_last  <= i_last;
                hd_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_p2s_stream.sv
// Three configurations (8/1 LSB, 8/2 MSB, 8/8) checked against a word-queue
// reference model under directed and random traffic.
module tb_p2s_stream;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr;
    logic [7:0] din  [3];
    logic       dv   [3];
    logic       lst  [3];
    logic       rdy  [3];
    logic [7:0] dout [3];
    logic       ordy [3];
    logic       odv  [3];
    logic       olast[3];
    logic       obusy[3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mode[3];
    bit acc [3];

    // Reference model: ring of accepted words plus symbol index of the head word.
    int         mcnt[3];
    int         rp  [3];
    int         wp  [3];
    int         sidx[3];
    logic [7:0] wd  [3][4];
    logic       wl  [3][4];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int SW = (k == 0) ? 1 : ((k == 1) ? 2 : 8);
        localparam int MF = (k == 1) ? 1 : 0;
        logic [SW-1:0] sym;
        p2s_stream #(.DATA_W(8), .SYM_W(SW), .MSB_FIRST(MF)) u_dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .i_clr  (clr),
            .i_data (din[k]),
            .i_last (lst[k]),
            .i_dv   (dv[k]),
            .o_ready(ordy[k]),
            .o_data (sym),
            .o_last (olast[k]),
            .o_dv   (odv[k]),
            .i_ready(rdy[k]),
            .o_busy (obusy[k])
        );
        assign dout[k] = 8'(sym);
    end

    function automatic int symw(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic int nsym(input int k);
        return 8 / symw(k);
    endfunction

    function automatic logic [7:0] exp_sym(input int k, input logic [7:0] w, input int s);
        int         sw;
        int         sh;
        logic [7:0] mask;
        sw   = symw(k);
        mask = 8'((1 << sw) - 1);
        sh   = (k == 1) ? (8 - (s + 1) * sw) : (s * sw);
        return (w >> sh) & mask;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic flush();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; rp[k] = 0; wp[k] = 0; sidx[k] = 0;
        end
    endtask

    task automatic chk_idle(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_dv%0d", tag, k),    odv[k],   0);
            chk($sformatf("%s_busy%0d", tag, k),  obusy[k], 0);
            chk($sformatf("%s_rdy%0d", tag, k),   ordy[k],  1);
            chk($sformatf("%s_data%0d", tag, k),  dout[k],  0);
            chk($sformatf("%s_last%0d", tag, k),  olast[k], 0);
        end
    endtask

    // One clock: check outputs against the model, then advance model on the edge.
    task automatic cycle();
        bit         inf[3];
        bit         of [3];
        bit         ex_dv;
        bit         ex_last;
        logic [7:0] w;
        for (int k = 0; k < 3; k++) begin
            case (mode[k])
                0:       rdy[k] = 1'b1;
                1:       rdy[k] = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       rdy[k] = 1'($urandom_range(0, 1));
                default: rdy[k] = 1'b0;
            endcase
        end
        for (int k = 0; k < 3; k++) begin
            ex_dv   = mcnt[k] > 0;
            w       = wd[k][rp[k]];
            ex_last = ex_dv && wl[k][rp[k]] && (sidx[k] == nsym(k) - 1);
            chk($sformatf("dv%0d", k),   odv[k],   32'(ex_dv));
            chk($sformatf("busy%0d", k), obusy[k], 32'(ex_dv));
            chk($sformatf("rdy%0d", k),  ordy[k],  32'(mcnt[k] < 2));
            chk($sformatf("last%0d", k), olast[k], 32'(ex_last));
            if (ex_dv)
                chk($sformatf("data%0d", k), dout[k], 32'(exp_sym(k, w, sidx[k])));
            inf[k] = dv[k] && (mcnt[k] < 2);
            of[k]  = ex_dv && rdy[k];
            acc[k] = inf[k] && !clr;
        end
        @(posedge clk);
        cyc++;
        if (clr) begin
            flush();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (of[k]) begin
                    if (sidx[k] == nsym(k) - 1) begin
                        sidx[k] = 0;
                        rp[k]   = (rp[k] + 1) % 4;
                        mcnt[k]--;
                    end else begin
                        sidx[k]++;
                    end
                end
                if (inf[k]) begin
                    wd[k][wp[k]] = din[k];
                    wl[k][wp[k]] = lst[k];
                    wp[k]        = (wp[k] + 1) % 4;
                    mcnt[k]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic drive_word(input int k, input logic [7:0] d, input logic l);
        bit done;
        done   = 1'b0;
        din[k] = d;
        lst[k] = l;
        dv[k]  = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle();
            done = acc[k];
        end
        chk($sformatf("accept%0d", k), 32'(done), 1);
        dv[k] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dv[k] = 1'b0; din[k] = '0; lst[k] = 1'b0; rdy[k] = 1'b1; mode[k] = 0;
        end
        flush();
        #12;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single LSB-first bit-serial word.
        drive_word(0, 8'hB2, 1'b0);
        idle(10);

        // Back-to-back MSB-first 2-bit symbols with frame end on second word.
        drive_word(1, 8'hE4, 1'b0);
        drive_word(1, 8'h1B, 1'b1);
        idle(8);

        // Stalling downstream while the holding register fills.
        mode[0] = 1;
        drive_word(0, 8'hA5, 1'b0);
        drive_word(0, 8'h3C, 1'b1);
        drive_word(0, 8'h5A, 1'b0);
        idle(30);
        mode[0] = 0;
        idle(10);

        // Whole-word symbols: two-deep word buffer under backpressure.
        mode[2] = 3;
        drive_word(2, 8'h01, 1'b0);
        drive_word(2, 8'h02, 1'b0);
        din[2] = 8'h03;
        dv[2]  = 1'b1;
        cycle();
        chk("full_rdy2", ordy[2], 0);
        dv[2]   = 1'b0;
        mode[2] = 0;
        drive_word(2, 8'h03, 1'b0);
        drive_word(2, 8'h04, 1'b1);
        idle(5);

        // Asynchronous reset part-way through a word.
        drive_word(0, 8'hC3, 1'b1);
        idle(3);
        #2 rst_n = 1'b0;
        #1 chk_idle("async_rst");
        flush();
        @(negedge clk);
        rst_n = 1'b1;
        drive_word(0, 8'h96, 1'b1);
        idle(10);

        // Synchronous clear with both stages full and a word on offer.
        mode[1] = 3;
        drive_word(1, 8'h11, 1'b0);
        drive_word(1, 8'h22, 1'b0);
        chk("pre_clr_rdy1", ordy[1], 0);
        din[1] = 8'h33;
        dv[1]  = 1'b1;
        clr    = 1'b1;
        cycle();
        clr    = 1'b0;
        dv[1]  = 1'b0;
        chk("clr_busy1", obusy[1], 0);
        chk("clr_dv1",   odv[1],   0);
        mode[1] = 0;
        idle(5);

        // Random traffic on all configurations.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 3; k++) begin
                mode[k] = 2;
                dv[k]   = $urandom_range(0, 9) < 6;
                din[k]  = 8'($urandom);
                lst[k]  = 1'($urandom_range(0, 1));
            end
            clr = ($urandom_range(0, 63) == 0);
            cycle();
        end
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dv[k] = 1'b0; mode[k] = 0;
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p2s_stream.md
Name: p2s_stream

Overview:
- Parameterised parallel-to-serial converter with valid/ready handshaking on both sides. It is the successor of the fixed single-bit, no-backpressure serialiser.
- Each accepted DATA_W-bit word is emitted as DATA_W/SYM_W symbols of SYM_W bits, in a selectable bit order. Frame markers travel with the words.
- A one-word holding register lets words stream back-to-back at full symbol rate. It sits between word-parallel encoder outputs and bit- or symbol-serial channel/modulator stages.

Parameters:
- DATA_W, 8, input word width in bits; must be a multiple of SYM_W.
- SYM_W, 1, output symbol width in bits; legal range 1..DATA_W.
- MSB_FIRST, 0, 0 = emit least-significant symbol first; 1 = emit most-significant symbol first.

Ports:
- i_clk  in  1  clock, all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clr  in  1  synchronous clear; discards all held and in-flight data.
- i_data  in  DATA_W  parallel input word.
- i_last  in  1  marks the word as the last of a frame.
- i_dv  in  1  input word valid.
- o_ready  out  1  block can accept a word this cycle.
- o_data  out  SYM_W  current output symbol.
- o_last  out  1  high on the final symbol of a last-marked word.
- o_dv  out  1  output symbol valid.
- i_ready  in  1  downstream accepts the symbol this cycle.
- o_busy  out  1  shift register or holding register occupied.

Behaviour:
- Definitions:
  - N_SYM = DATA_W/SYM_W.
  - Counter width CNT_W = max(1, $clog2(N_SYM)).
  - in_fire = i_dv & o_ready.
  - out_fire = o_dv & i_ready.
  - word_end = out_fire & (cnt == 0).
- Storage:
  - Shift stage: sh_reg, sh_last, sh_valid, cnt (symbols remaining minus one).
  - Hold stage: hd_reg, hd_last, hd_valid.
- Combinational outputs:
  - o_ready = !hd_valid.
  - o_dv = sh_valid.
  - o_busy = sh_valid | hd_valid.
  - o_data = sh_reg[SYM_W-1:0] when MSB_FIRST = 0; sh_reg[DATA_W-1 -: SYM_W] when MSB_FIRST = 1.
  - o_last = sh_valid & sh_last & (cnt == 0).
- Reset (i_rst_n low, asynchronous):
  - All registers clear: sh_valid = 0, hd_valid = 0, cnt = 0, data registers = 0.
  - Outputs: o_dv = 0, o_last = 0, o_busy = 0, o_ready = 1, o_data = 0.
  - Reset mid-word drops the word with no partial completion.
- i_clr (synchronous) has the same effect as reset on the next edge and overrides all other events that cycle. Input is not accepted in a clear cycle even if o_ready = 1.
- Shift stage update, in priority order:
  - If (!sh_valid | word_end):
    - hd_valid: load hd into shift, clear hd_valid.
    - Else if in_fire: load i_data/i_last directly into shift.
    - Else: sh_valid <= 0.
    - Any load sets sh_valid = 1 and cnt = N_SYM-1.
  - Else if out_fire: shift sh_reg by SYM_W toward the output end, zero-fill, cnt <= cnt-1.
  - Else: hold all state (stall; o_data stable while o_dv & !i_ready).
- Hold stage:
  - Captures i_data/i_last when in_fire and the word was not loaded directly into shift that cycle.
  - Simultaneous hd-to-shift move and in_fire: the new word goes into hd, hd_valid stays 1.
- Latency and throughput:
  - Accepted word appears at o_dv one cycle after acceptance if the shift stage is empty.
  - Sustained throughput is one symbol per cycle with no bubbles between words while i_ready = 1.
- N_SYM = 1 (SYM_W = DATA_W): every out_fire is a word_end; the block behaves as a 2-deep word FIFO.
- Input-side stability: i_data/i_last are sampled only on in_fire; no stability is required otherwise.
- Output-side stability: o_data, o_last and o_dv must not change while o_dv & !i_ready.

Decomposition:
- Package p2s_pkg:
  - Function clog2_min1(n).
  - Elaboration-time check macro/assertion that DATA_W % SYM_W == 0 and SYM_W >= 1.
- Sub-module p2s_shift_core: shift register, cnt, sh_last, symbol select by MSB_FIRST, word_end generation.
- The top level holds the hold stage and handshake logic.

Test Plan:
- DATA_W=8, SYM_W=1, MSB_FIRST=0, i_ready=1; single word 0xB2 -> o_data bits 0,1,0,0,1,1,0,1 on 8 consecutive cycles starting one cycle after accept; o_dv then drops.
- DATA_W=8, SYM_W=2, MSB_FIRST=1; words 0xE4 (i_last=0) then 0x1B (i_last=1) offered back-to-back -> symbols 3,2,1,0,0,1,2,3 with no gap; o_last high only on the 8th symbol; o_ready low for exactly the cycles hd is full.
- Backpressure: toggle i_ready 1,0,0,1,... during word 0xA5 -> o_data held stable while stalled; all 8 symbols delivered exactly once in order; third word not accepted until hd frees.
- N_SYM=1 (DATA_W=SYM_W=8): stream 0x01..0x04 with i_ready low for 3 cycles -> at most 2 words stored, o_ready=0 when both full, outputs 0x01..0x04 in order.
- i_rst_n asserted asynchronously mid-word (after 3 of 8 symbols) -> o_dv, o_busy fall immediately; o_ready=1; next word after release is output from its first symbol.
- i_clr pulsed with i_dv=1 while both stages full -> next cycle o_busy=0, o_dv=0; the word offered during the clear cycle is not accepted.
